// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Moore-style main controller for a multicycle RV32I core. Steps
//            the datapath through fetch/decode/execute/memory/writeback,
//            waits on a req/ready memory port under a watchdog, flags
//            unsupported instructions and counts retired instructions.
// Ports    : clk, rst (async, active-low)
//            op/funct3/funct7b5 : instruction fields from IR
//            zero               : ALU zero flag (branch resolution)
//            mem_ready          : memory completes the current access
//            mem_req/mem_write/adr_src          : memory port control
//            ir_write/pc_write/reg_write        : architectural write strobes
//            result_src/alu_src_a/alu_src_b/alu_control/imm_src : datapath
//            illegal/mem_timeout : sticky fault flags
//            instret             : retired-instruction counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int unsigned WAIT_LIMIT = 255,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [2:0]       imm_src,
    output logic             illegal,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instret
);

    localparam logic [3:0] c_fetch    = 4'd0;
    localparam logic [3:0] c_decode   = 4'd1;
    localparam logic [3:0] c_memadr   = 4'd2;
    localparam logic [3:0] c_memread  = 4'd3;
    localparam logic [3:0] c_memwb    = 4'd4;
    localparam logic [3:0] c_memwrite = 4'd5;
    localparam logic [3:0] c_execr    = 4'd6;
    localparam logic [3:0] c_execi    = 4'd7;
    localparam logic [3:0] c_aluwb    = 4'd8;
    localparam logic [3:0] c_branch   = 4'd9;
    localparam logic [3:0] c_jal      = 4'd10;
    localparam logic [3:0] c_jalr1    = 4'd11;
    localparam logic [3:0] c_jalr2    = 4'd12;
    localparam logic [3:0] c_lui      = 4'd13;
    localparam logic [3:0] c_trap     = 4'd14;
    localparam logic [3:0] c_timeout  = 4'd15;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_xor = 3'b100;
    localparam logic [2:0] c_alu_slt = 3'b101;
    localparam logic [2:0] c_alu_sll = 3'b110;
    localparam logic [2:0] c_alu_srl = 3'b111;

    // Last wait count that may still be followed by a ready cycle.
    localparam logic [15:0] c_wait_last = 16'(WAIT_LIMIT - 1);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [15:0]      r_wait_cnt;
    logic             r_illegal;
    logic             r_timeout;
    logic [CNT_W-1:0] r_instret;

    logic       w_mem_req, w_mem_write, w_adr_src;
    logic       w_ir_write, w_pc_write, w_reg_write;
    logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b;
    logic [2:0] w_alu_control, w_imm_src;
    logic [2:0] w_alu_f3;
    logic       w_alu_f3_ok;
    logic       w_wait_expired;

    // ALU operation implied by funct3 (shared by register and immediate forms)
    always_comb begin
        w_alu_f3    = c_alu_add;
        w_alu_f3_ok = 1'b1;
        case (funct3)
            3'b000:  w_alu_f3 = c_alu_add;
            3'b111:  w_alu_f3 = c_alu_and;
            3'b110:  w_alu_f3 = c_alu_or;
            3'b100:  w_alu_f3 = c_alu_xor;
            3'b010:  w_alu_f3 = c_alu_slt;
            3'b001:  w_alu_f3 = c_alu_sll;
            3'b101:  w_alu_f3 = c_alu_srl;
            default: w_alu_f3_ok = 1'b0;
        endcase
    end

    // Immediate format follows the opcode regardless of state
    always_comb begin
        w_imm_src = 3'd0;
        case (op)
            c_op_branch: w_imm_src = 3'd1;
            c_op_store:  w_imm_src = 3'd2;
            c_op_jal:    w_imm_src = 3'd3;
            c_op_lui:    w_imm_src = 3'd4;
            default:     w_imm_src = 3'd0;
        endcase
    end

    assign w_wait_expired = w_mem_req && !mem_ready && (r_wait_cnt == c_wait_last);

    always_comb begin
        w_next        = r_state;
        w_mem_req     = 1'b0;
        w_mem_write   = 1'b0;
        w_adr_src     = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_result_src  = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_alu_control = c_alu_add;
        case (r_state)
            c_fetch: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = c_decode;
                end
            end
            c_decode: begin
                // Branch target is precomputed into ALUOut here
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (op)
                    c_op_load, c_op_store: w_next = c_memadr;
                    c_op_rtype:            w_next = c_execr;
                    c_op_itype:            w_next = c_execi;
                    c_op_branch:           w_next = (funct3[2:1] == 2'b00) ? c_branch : c_trap;
                    c_op_jal:              w_next = c_jal;
                    c_op_jalr:             w_next = c_jalr1;
                    c_op_lui:              w_next = c_lui;
                    default:               w_next = c_trap;
                endcase
            end
            c_memadr: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = (op == c_op_load) ? c_memread : c_memwrite;
            end
            c_memread: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (mem_ready) w_next = c_memwb;
            end
            c_memwb: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next       = c_fetch;
            end
            c_memwrite: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                if (mem_ready) w_next = c_fetch;
            end
            c_execr: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = (funct3 == 3'b000 && funct7b5) ? c_alu_sub : w_alu_f3;
                w_next        = w_alu_f3_ok ? c_aluwb : c_trap;
            end
            c_execi: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_alu_control = w_alu_f3;
                w_next        = w_alu_f3_ok ? c_aluwb : c_trap;
            end
            c_aluwb: begin
                w_reg_write = 1'b1;
                w_next      = c_fetch;
            end
            c_branch: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = c_alu_sub;
                // funct3[0] distinguishes bne from beq
                w_pc_write    = funct3[0] ? !zero : zero;
                w_next        = c_fetch;
            end
            c_jal: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
                w_next      = c_aluwb;
            end
            c_jalr1: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = c_jalr2;
            end
            c_jalr2: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
                w_next      = c_aluwb;
            end
            c_lui: begin
                w_alu_src_a = 2'b11;
                w_alu_src_b = 2'b01;
                w_next      = c_aluwb;
            end
            c_trap:    w_next = c_trap;
            c_timeout: w_next = c_timeout;
            default:   w_next = c_trap;
        endcase
        // Watchdog overrides the hold; a ready in the same cycle never expires
        if (w_wait_expired) w_next = c_timeout;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_fetch;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_timeout  <= 1'b0;
            r_instret  <= '0;
        end else begin
            r_state <= w_next;
            if (w_mem_req && !mem_ready && (w_next == r_state))
                r_wait_cnt <= r_wait_cnt + 16'd1;
            else
                r_wait_cnt <= '0;
            if (w_next == c_trap)    r_illegal <= 1'b1;
            if (w_next == c_timeout) r_timeout <= 1'b1;
            if (w_next == c_fetch && r_state != c_fetch)
                r_instret <= r_instret + 1'b1;
        end
    end

    // While reset is held the state register already reads FETCH, so the
    // decoded controls are masked to keep every strobe and select at zero.
    assign mem_req     = rst & w_mem_req;
    assign mem_write   = rst & w_mem_write;
    assign adr_src     = rst & w_adr_src;
    assign ir_write    = rst & w_ir_write;
    assign pc_write    = rst & w_pc_write;
    assign reg_write   = rst & w_reg_write;
    assign result_src  = rst ? w_result_src  : 2'b00;
    assign alu_src_a   = rst ? w_alu_src_a   : 2'b00;
    assign alu_src_b   = rst ? w_alu_src_b   : 2'b00;
    assign alu_control = rst ? w_alu_control : 3'b000;
    assign imm_src     = rst ? w_imm_src     : 3'b000;
    assign illegal     = r_illegal;
    assign mem_timeout = r_timeout;
    assign instret     = r_instret;

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main FSM for the multicycle RV32I core.
- Sequences PC, instruction register, register file, ALU, memory port and the immediate extender (drives its 3-bit ImmSrc) across fetch/decode/execute/memory/writeback.
- Handles variable-latency memory with a req/ready handshake and a wait watchdog.
- Flags illegal instructions and retires a per-instruction counter.

Parameters:
WAIT_LIMIT, 255, max cycles mem_req may stay high without mem_ready before timeout trap (range 1..65535)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
op  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_write  out  1  store enable, qualified by mem_req
adr_src  out  1  0=PC, 1=ALUOut
ir_write  out  1  load IR (and oldPC)
pc_write  out  1  load PC from result bus
reg_write  out  1  register file write
result_src  out  2  00=ALUOut, 01=mem data, 10=ALU result
alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1, 11=zero
alu_src_b  out  2  00=rs2, 01=ImmExt, 10=const 4
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
imm_src  out  3  0=I, 1=B, 2=S, 3=J, 4=U
illegal  out  1  sticky: unsupported opcode/funct3
mem_timeout  out  1  sticky: watchdog expired
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset while rst low: state=FETCH, illegal=0, mem_timeout=0, instret=0, wait counter=0. All strobes (mem_req, mem_write, ir_write, pc_write, reg_write) forced 0. All selects and alu_control = 0.
- Reset mid-instruction: aborts immediately; no partial writes after rst falls.
- Outputs are decoded from state, plus op/funct3/funct7b5/zero where noted.
- imm_src is decoded from op in every state:
  - lw/jalr/I-ALU → 0
  - branch → 1
  - sw → 2
  - jal → 3
  - lui → 4
  - otherwise 0
- FETCH: mem_req=1, adr_src=0.
  - Holds until mem_ready.
  - On mem_ready: ir_write=1, pc_write=1, A=PC, B=4, add, result_src=10 → DECODE.
- DECODE: A=oldPC, B=ImmExt, add (precomputes branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH if funct3 ∈ {000,001}, else TRAP
  - 1101111 → JAL
  - 1100111 → JALR1
  - 0110111 → LUI
  - else → TRAP
- MEMADR: A=rs1, B=ImmExt, add → MEMREAD (lw) / MEMWRITE (sw).
- MEMREAD: mem_req=1, adr_src=1; on mem_ready → MEMWB.
- MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, held until mem_ready → FETCH.
- EXECR: A=rs1, B=rs2 → ALUWB. alu_control from funct3:
  - 000 → add, or sub if funct7b5
  - 111 → and
  - 110 → or
  - 100 → xor
  - 010 → slt
  - 001 → sll
  - 101 → srl
  - others → TRAP
- EXECI: as EXECR with B=ImmExt; funct7b5 ignored for 000 (always add) → ALUWB.
- ALUWB: result_src=00, reg_write=1 → FETCH.
- BRANCH: A=rs1, B=rs2, sub, result_src=00.
  - pc_write = zero (beq) or !zero (bne).
  - → FETCH.
- JAL: A=oldPC, B=4, add, result_src=00, pc_write=1 → ALUWB (writes link).
- JALR1: A=rs1, B=ImmExt, add → JALR2.
- JALR2: result_src=00, pc_write=1; A=oldPC, B=4, add → ALUWB.
- LUI: A=zero, B=ImmExt, add → ALUWB.
- TRAP: all strobes 0, illegal=1; absorbing until reset.
- Watchdog:
  - Counter increments each cycle mem_req=1 && mem_ready=0; clears on mem_ready or state change.
  - When count reaches WAIT_LIMIT with mem_ready still low: mem_timeout=1 → TIMEOUT state.
  - TIMEOUT: strobes 0; absorbing until reset.
  - mem_ready on the same cycle as the limit is reached wins (no timeout).
- instret increments by 1 on each transition into FETCH from a non-reset state; wraps modulo 2^CNT_W.
- Latency with zero-wait memory:
  - R/I-ALU, lui, branch: 4/4/4/3 cycles
  - lw 5, sw 4, jal 4, jalr 5

Test Plan:
- Release reset, op=0110011, funct3=000, funct7b5=1, mem_ready=1 → states FETCH,DECODE,EXECR,ALUWB; alu_control=001 in EXECR; reg_write=1 one cycle; instret=1 after return to FETCH.
- lw with mem_ready low 3 cycles in MEMREAD → mem_req held 4 cycles, adr_src=1, imm_src=0; then MEMWB result_src=01, reg_write=1.
- op=1100011, funct3=001, zero=0 → pc_write=1 in BRANCH, imm_src=1; repeat with zero=1 → pc_write=0; funct3=100 → TRAP, illegal=1 sticky.
- jalr → JALR1,JALR2 (pc_write=1),ALUWB (reg_write=1); lui → imm_src=4, alu_src_a=11.
- WAIT_LIMIT=4, mem_ready held low in FETCH → mem_timeout=1 after 4 wait cycles, no strobes afterwards; same run with mem_ready rising on cycle 4 → no timeout.
- Assert rst low during MEMWRITE → mem_write/mem_req drop immediately; instret=0; after release, restart at FETCH.
